// File: rtl/game_over_text_renderer.sv
// rtl/game_over_text_renderer.sv - "GAME OVER" text overlay stage feeding an 8x8 glyph ROM
//
// Purpose:
//   Maps each incoming pixel coordinate onto the "GAME OVER" text box, drives
//   the letter code of the character under the pixel to an external registered
//   glyph ROM, and combines the returned 8x8 glyph with the delay-matched
//   row/column into a per-pixel text_on bit. A frame-synchronous state machine
//   shows the text while game_over is high and can optionally blink it.
//
// Configuration macro:
//   GAME_OVER_BLINK_EN - when defined, the text alternates between shown and
//                        hidden every BLINK_FRAMES frames. When undefined the
//                        blink state and frame counter are not built and the
//                        text stays shown while game_over is high.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   game_over    level, text enabled while high
//   frame_start  one-cycle pulse at the first pixel of each frame
//   px_valid     px_x/px_y describe an active-area pixel
//   px_x, px_y   pixel column / row
//   letter       registered letter code to the glyph ROM (4'hF = blank)
//   glyph        ROM output, row r = glyph[8r+7:8r], bit 7 = leftmost pixel
//   text_on      registered, pixel is lit by text
//   text_valid   px_valid delayed to line up with text_on

module game_over_text_renderer #(
    parameter int COORD_W      = 11,
    parameter int ORIGIN_X     = 256,
    parameter int ORIGIN_Y     = 200,
    parameter int SCALE_LOG2   = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               game_over,
    input  logic               frame_start,
    input  logic               px_valid,
    input  logic [COORD_W-1:0] px_x,
    input  logic [COORD_W-1:0] px_y,
    output logic [3:0]         letter,
    input  logic [63:0]        glyph,
    output logic               text_on,
    output logic               text_valid
);

    // One character cell is 8 glyph pixels, each magnified by 2^SCALE_LOG2.
    localparam int CHAR_SHIFT = 3 + SCALE_LOG2;

    // One extra bit so the box size never aliases into the coordinate width.
    localparam logic [COORD_W:0]   BOX_W = (COORD_W+1)'(9 << CHAR_SHIFT);
    localparam logic [COORD_W:0]   BOX_H = (COORD_W+1)'(8 << CHAR_SHIFT);
    localparam logic [COORD_W-1:0] ORG_X = COORD_W'(ORIGIN_X);
    localparam logic [COORD_W-1:0] ORG_Y = COORD_W'(ORIGIN_Y);

    localparam logic [3:0] BLANK = 4'hF;

    generate
        if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink
            $error("BLINK_FRAMES must be within 1..255");
        end
    endgenerate

    // Letter codes for "GAME OVER"; the space and anything past the end are blank.
    function automatic logic [3:0] letter_code(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h0;   // G
            4'd1:    code = 4'h1;   // A
            4'd2:    code = 4'h2;   // M
            4'd3:    code = 4'h3;   // E
            4'd5:    code = 4'h4;   // O
            4'd6:    code = 4'h5;   // V
            4'd7:    code = 4'h3;   // E
            4'd8:    code = 4'h6;   // R
            default: code = BLANK;  // space
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Coordinate decode (combinational, feeds stage 1)
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic               in_box_c;
    logic [3:0]         char_idx_c;
    logic [2:0]         col_c;
    logic [2:0]         row_c;

    always_comb begin
        dx = px_x - ORG_X;
        dy = px_y - ORG_Y;
        // The >= origin tests guard the subtraction: without them a pixel
        // left of / above the box would wrap to a large dx/dy and could
        // alias back into the box for small coordinate widths.
        in_box_c   = px_valid
                   && (px_x >= ORG_X) && (px_y >= ORG_Y)
                   && ({1'b0, dx} < BOX_W) && ({1'b0, dy} < BOX_H);
        char_idx_c = 4'(dx >> CHAR_SHIFT);
        col_c      = 3'(dx >> SCALE_LOG2);
        row_c      = 3'(dy >> SCALE_LOG2);
    end

    // ------------------------------------------------------------------
    // Display state machine
    // ------------------------------------------------------------------
`ifdef GAME_OVER_BLINK_EN
    typedef enum logic [1:0] {
        HIDDEN    = 2'd0,
        SHOW      = 2'd1,
        BLINK_OFF = 2'd2
    } state_t;

    localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

    state_t     state;
    logic [7:0] frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HIDDEN;
            frame_cnt <= 8'd0;
        end else if (!game_over) begin
            // Dropping game_over hides the text immediately, mid-frame.
            state     <= HIDDEN;
            frame_cnt <= 8'd0;
        end else if (frame_start) begin
            case (state)
                HIDDEN: begin
                    state     <= SHOW;
                    frame_cnt <= 8'd0;
                end
                SHOW: begin
                    if (frame_cnt == LAST_FRAME) begin
                        state     <= BLINK_OFF;
                        frame_cnt <= 8'd0;
                    end else begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                BLINK_OFF: begin
                    if (frame_cnt == LAST_FRAME) begin
                        state     <= SHOW;
                        frame_cnt <= 8'd0;
                    end else begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= HIDDEN;
                    frame_cnt <= 8'd0;
                end
            endcase
        end
    end
`else
    typedef enum logic {
        HIDDEN = 1'b0,
        SHOW   = 1'b1
    } state_t;

    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HIDDEN;
        end else if (!game_over) begin
            state <= HIDDEN;
        end else if (frame_start) begin
            state <= SHOW;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Pixel pipeline
    //   stage 1: letter to ROM, capture row/col/in_box/valid
    //   stage 2: ROM registers the glyph; side info delayed to match
    //   stage 3: pick the glyph bit and gate it with visibility
    // ------------------------------------------------------------------
    logic [2:0] s1_row;
    logic [2:0] s1_col;
    logic       s1_in_box;
    logic       s1_valid;
    logic [2:0] s2_row;
    logic [2:0] s2_col;
    logic       s2_in_box;
    logic       s2_valid;
    logic       glyph_bit;

    // Bit 7 of a glyph row is the leftmost pixel, so column c lives at
    // bit 7-c, which for a 3-bit column is simply its complement.
    assign glyph_bit = glyph[{s2_row, ~s2_col}];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            letter     <= BLANK;
            s1_row     <= 3'd0;
            s1_col     <= 3'd0;
            s1_in_box  <= 1'b0;
            s1_valid   <= 1'b0;
            s2_row     <= 3'd0;
            s2_col     <= 3'd0;
            s2_in_box  <= 1'b0;
            s2_valid   <= 1'b0;
            text_on    <= 1'b0;
            text_valid <= 1'b0;
        end else begin
            letter     <= in_box_c ? letter_code(char_idx_c) : BLANK;
            s1_row     <= row_c;
            s1_col     <= col_c;
            s1_in_box  <= in_box_c;
            s1_valid   <= px_valid;

            s2_row     <= s1_row;
            s2_col     <= s1_col;
            s2_in_box  <= s1_in_box;
            s2_valid   <= s1_valid;

            text_on    <= s2_valid && s2_in_box && (state == SHOW) && glyph_bit;
            text_valid <= s2_valid;
        end
    end

endmodule

// File: tb/tb_game_over_text_renderer.sv
// tb/tb_game_over_text_renderer.sv - randomized self-checking bench for game_over_text_renderer

module tb_game_over_text_renderer;

    localparam int BF = 2;

`ifdef GAME_OVER_BLINK_EN
    localparam bit BLINK_MODE = 1'b1;
`else
    localparam bit BLINK_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        game_over = 1'b0;
    logic        frame_start = 1'b0;
    logic        px_valid = 1'b0;
    logic [10:0] px_x = '0;
    logic [10:0] px_y = '0;
    logic [3:0]  letter;
    logic [63:0] glyph = '0;
    logic        text_on;
    logic        text_valid;

    always #5 clk = ~clk;

    game_over_text_renderer #(
        .COORD_W     (11),
        .ORIGIN_X    (256),
        .ORIGIN_Y    (200),
        .SCALE_LOG2  (2),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .game_over  (game_over),
        .frame_start(frame_start),
        .px_valid   (px_valid),
        .px_x       (px_x),
        .px_y       (px_y),
        .letter     (letter),
        .glyph      (glyph),
        .text_on    (text_on),
        .text_valid (text_valid)
    );

    // Registered glyph ROM
    logic [63:0] rom [16];
    always @(posedge clk) glyph <= rom[letter];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        int x;
        int y;
    } pix_t;

    pix_t h1, h2;
    bit   m_on;
    int   m_frames;

    function automatic bit ref_in_box(pix_t p);
        return p.v && p.x >= 256 && p.x < 256 + 9 * 32 && p.y >= 200 && p.y < 200 + 8 * 32;
    endfunction

    function automatic logic [3:0] ref_letter(pix_t p);
        string s;
        byte   c;
        s = "GAME OVER";
        if (!ref_in_box(p)) return 4'hF;
        c = s[(p.x - 256) / 32];
        case (c)
            "G":     return 4'h0;
            "A":     return 4'h1;
            "M":     return 4'h2;
            "E":     return 4'h3;
            "O":     return 4'h4;
            "V":     return 4'h5;
            "R":     return 4'h6;
            default: return 4'hF;
        endcase
    endfunction

    function automatic bit ref_visible();
        if (!m_on) return 1'b0;
        if (!BLINK_MODE) return 1'b1;
        return ((m_frames / BF) % 2) == 0;
    endfunction

    function automatic bit ref_pixel(pix_t p);
        int row, col;
        logic [63:0] g;
        if (!ref_in_box(p)) return 1'b0;
        row = ((p.y - 200) / 4) % 8;
        col = ((p.x - 256) / 4) % 8;
        g   = rom[ref_letter(p)];
        return g[8 * row + 7 - col];
    endfunction

    // Applies the current inputs for one clock edge and checks all outputs.
    task automatic tick();
        pix_t       cur;
        logic [3:0] el;
        bit         eon, etv;
        cur.v = px_valid;
        cur.x = int'(px_x);
        cur.y = int'(px_y);
        if (!rst_n) begin
            el = 4'hF; eon = 1'b0; etv = 1'b0;
            h1 = '{1'b0, 0, 0};
            h2 = '{1'b0, 0, 0};
            m_on = 1'b0; m_frames = 0;
        end else begin
            el  = ref_letter(cur);
            etv = h2.v;
            eon = h2.v && ref_visible() && ref_pixel(h2);
            if (!game_over) m_on = 1'b0;
            else if (frame_start) begin
                if (!m_on) begin
                    m_on = 1'b1;
                    m_frames = 0;
                end else begin
                    m_frames++;
                end
            end
            h2 = h1;
            h1 = cur;
        end
        @(posedge clk);
        #1;
        check("letter", 64'(letter), 64'(el));
        check("text_on", 64'(text_on), 64'(eon));
        check("text_valid", 64'(text_valid), 64'(etv));
    endtask

    task automatic pix(input bit v, input int x, input int y);
        px_valid = v;
        px_x = 11'(x);
        px_y = 11'(y);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = {$urandom, $urandom};
        rom[0][7:0] = 8'b00111100;
        h1 = '{1'b0, 0, 0};
        h2 = '{1'b0, 0, 0};
        m_on = 1'b0;
        m_frames = 0;

        // Reset state
        tick();
        tick();
        #2 rst_n = 1'b1;

        // Enable text on a frame boundary
        game_over = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;

        // Glyph G, row 0 = 00111100
        pix(1, 256, 200);
        check("g_letter", 64'(letter), 64'h0);
        pix(1, 264, 200);
        pix(0, 0, 0);
        check("g_col0_dark", 64'(text_on), 64'h0);
        pix(0, 0, 0);
        check("g_col2_lit", 64'(text_on), 64'h1);

        // Character boundaries, space and out-of-box pixels
        pix(1, 287, 200);  check("x287", 64'(letter), 64'h0);
        pix(1, 288, 200);  check("x288", 64'(letter), 64'h1);
        pix(1, 543, 455);  check("x543", 64'(letter), 64'h6);
        pix(1, 544, 200);  check("x544", 64'(letter), 64'hF);
        pix(1, 384, 210);  check("space", 64'(letter), 64'hF);
        pix(1, 255, 200);  check("left", 64'(letter), 64'hF);
        pix(1, 300, 199);  check("above", 64'(letter), 64'hF);
        pix(1, 400, 456);  check("below", 64'(letter), 64'hF);
        pix(0, 0, 0);
        pix(0, 0, 0);

        // Randomized stream
        for (int i = 0; i < 4000; i++) begin
            int x, y;
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(240, 560));
            y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(190, 470));
            frame_start = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 299) == 0) game_over = ~game_over;
            pix($urandom_range(0, 7) != 0, x, y);
        end
        frame_start = 1'b0;

        // Blink sequence on a constant lit pixel
        game_over = 1'b0;
        pix(1, 264, 200);
        game_over = 1'b1;
        for (int f = 1; f <= 5; f++) begin
            bit exp_on;
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            repeat (6) tick();
            exp_on = BLINK_MODE ? !(f == 3 || f == 4) : 1'b1;
            check($sformatf("blink_f%0d", f), 64'(text_on), 64'(exp_on));
        end

        // game_over dropped mid-frame
        game_over = 1'b0;
        repeat (3) tick();
        check("drop_off", 64'(text_on), 64'h0);

        // frame_start coincident with the drop: hidden wins
        game_over = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (4) tick();
        check("reshow", 64'(text_on), 64'h1);
        game_over = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        game_over = 1'b1;
        repeat (4) tick();
        check("coincident_hidden", 64'(text_on), 64'h0);

        // Asynchronous reset mid-stream
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (3) tick();
        #3 rst_n = 1'b0;
        #1;
        check("rst_letter", 64'(letter), 64'hF);
        check("rst_text_on", 64'(text_on), 64'h0);
        check("rst_text_valid", 64'(text_valid), 64'h0);
        tick();
        px_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        tick();
        pix(1, 264, 200);
        check("rst_tv_e1", 64'(text_valid), 64'h0);
        tick();
        check("rst_tv_e2_pending", 64'(text_valid), 64'h0);
        tick();
        check("rst_tv_after2", 64'(text_valid), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
